// File: rtl/tone_arbiter_if.sv
// Tone-path bus shared between the note requesters and the tone arbiter.
// The requesters hold the master side; the arbiter holds the slave side.
interface tone_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int NOTE_BITS = 3,
  parameter int OCT_BITS  = 3,
  parameter int LEN_BITS  = 3
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ*NOTE_BITS-1:0] req_note;
  logic [N_REQ*OCT_BITS-1:0]  req_oct;
  logic [N_REQ*LEN_BITS-1:0]  req_len;
  logic [N_REQ-1:0]           flush;
  logic [N_REQ-1:0]           ack;
  logic [N_REQ-1:0]           done;
  logic [N_REQ-1:0]           grant;
  logic                       busy;
  logic                       snd_en;
  logic [NOTE_BITS-1:0]       snd_note;
  logic [OCT_BITS-1:0]        snd_oct;

  modport master (
    output req, req_note, req_oct, req_len, flush,
    input  ack, done, grant, busy, snd_en, snd_note, snd_oct
  );

  modport slave (
    input  req, req_note, req_oct, req_len, flush,
    output ack, done, grant, busy, snd_en, snd_note, snd_oct
  );
endinterface

// File: rtl/tone_arbiter.sv
// Fixed-priority, non-preemptive owner of the single Sound tone path.
// Each granted note is timed in ms ticks, then followed by a silent gap.
module tone_arbiter #(
  parameter int N_REQ     = 4,
  parameter int NOTE_BITS = 3,
  parameter int OCT_BITS  = 3,
  parameter int LEN_BITS  = 3,
  parameter int TICK_DIV  = 100000,
  parameter int UNIT_MS   = 125,
  parameter int GAP_MS    = 20
) (
  input  logic           clk,
  input  logic           rst,
  tone_arbiter_if.slave  bus
);

  localparam int TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PLAY_MAX   = (1 << LEN_BITS) * UNIT_MS;
  localparam int MS_MAX     = (PLAY_MAX > GAP_MS) ? PLAY_MAX : GAP_MS;
  localparam int MS_W       = $clog2(MS_MAX + 1);
  localparam int GAP_LAST_I = (GAP_MS > 0) ? GAP_MS - 1 : 0;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   GAP_LAST  = MS_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [MS_W-1:0]      ms_q, ms_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 en_q, en_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic [OCT_BITS-1:0]  oct_q, oct_d;

  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     sel_oh;
  logic [NOTE_BITS-1:0] sel_note;
  logic [OCT_BITS-1:0]  sel_oct;
  logic [LEN_BITS-1:0]  sel_len;
  logic                 tick;
  logic                 owner_flush;
  logic [MS_W-1:0]      play_last;

  // A requester flushing in the same cycle it requests is not a candidate;
  // the lowest set bit of the remaining candidates wins.
  always_comb begin
    eligible = bus.req & ~bus.flush;
    sel_oh   = eligible & (~eligible + N_REQ'(1));
    sel_note = '0;
    sel_oct  = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_note = bus.req_note[i*NOTE_BITS +: NOTE_BITS];
        sel_oct  = bus.req_oct[i*OCT_BITS +: OCT_BITS];
        sel_len  = bus.req_len[i*LEN_BITS +: LEN_BITS];
      end
    end
  end

  always_comb begin
    tick        = (tick_q == TICK_LAST);
    owner_flush = |(bus.flush & grant_q);
    play_last   = (MS_W'(len_q) + MS_W'(1)) * MS_W'(UNIT_MS) - MS_W'(1);
  end

  // Next-state and next-output logic; every register gets a hold default,
  // ack and done default low so they can only ever pulse for one cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    len_d   = len_q;
    ack_d   = '0;
    done_d  = '0;
    grant_d = grant_q;
    busy_d  = busy_q;
    en_d    = en_q;
    note_d  = note_q;
    oct_d   = oct_q;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        ms_d   = '0;
        if (|eligible) begin
          state_d = PLAY;
          ack_d   = sel_oh;
          grant_d = sel_oh;
          busy_d  = 1'b1;
          en_d    = (sel_note != '0);
          note_d  = sel_note;
          oct_d   = sel_oct;
          len_d   = sel_len;
        end
      end

      PLAY: begin
        if (owner_flush) begin
          state_d = IDLE;
          tick_d  = '0;
          ms_d    = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          tick_d = tick ? '0 : tick_q + TICK_W'(1);
          if (tick) begin
            if (ms_q == play_last) begin
              done_d = grant_q;
              en_d   = 1'b0;
              tick_d = '0;
              ms_d   = '0;
              if (GAP_MS > 0) begin
                state_d = GAP;
              end else begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
              end
            end else begin
              ms_d = ms_q + MS_W'(1);
            end
          end
        end
      end

      GAP: begin
        // The gap keeps the owner granted so a flush from it still aborts cleanly.
        if (owner_flush || (tick && ms_q == GAP_LAST)) begin
          state_d = IDLE;
          tick_d  = '0;
          ms_d    = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          tick_d = tick ? '0 : tick_q + TICK_W'(1);
          if (tick) begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
        ms_d    = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      ms_q    <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      note_q  <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.snd_en   = en_q;
  assign bus.snd_note = note_q;
  assign bus.snd_oct  = oct_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter: one DUT with a 1 ms gap, one with no gap.
// A note of length code L plays (L+1)*8 cycles here, and a gap lasts 4 cycles.
module tb_tone_arbiter;

  localparam int N_REQ     = 4;
  localparam int NOTE_BITS = 3;
  localparam int OCT_BITS  = 3;
  localparam int LEN_BITS  = 3;
  localparam int TICK_DIV  = 4;
  localparam int UNIT_MS   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt;
  logic oh_ok;

  tone_arbiter_if #(.N_REQ(N_REQ), .NOTE_BITS(NOTE_BITS), .OCT_BITS(OCT_BITS),
                    .LEN_BITS(LEN_BITS)) bus ();
  tone_arbiter_if #(.N_REQ(N_REQ), .NOTE_BITS(NOTE_BITS), .OCT_BITS(OCT_BITS),
                    .LEN_BITS(LEN_BITS)) bus0 ();

  tone_arbiter #(
    .N_REQ(N_REQ), .NOTE_BITS(NOTE_BITS), .OCT_BITS(OCT_BITS), .LEN_BITS(LEN_BITS),
    .TICK_DIV(TICK_DIV), .UNIT_MS(UNIT_MS), .GAP_MS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  tone_arbiter #(
    .N_REQ(N_REQ), .NOTE_BITS(NOTE_BITS), .OCT_BITS(OCT_BITS), .LEN_BITS(LEN_BITS),
    .TICK_DIV(TICK_DIV), .UNIT_MS(UNIT_MS), .GAP_MS(0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {ack, done, grant, busy, snd_en} so one line shows the whole handshake.
  task automatic checkOutput(input bit b0, input string tag, input logic [3:0] e_ack,
                             input logic [3:0] e_done, input logic [3:0] e_grant,
                             input logic e_busy, input logic e_en);
    logic [13:0] obs;
    if (b0) obs = {bus0.ack, bus0.done, bus0.grant, bus0.busy, bus0.snd_en};
    else    obs = {bus.ack, bus.done, bus.grant, bus.busy, bus.snd_en};
    checkVal(tag, 32'(obs), 32'({e_ack, e_done, e_grant, e_busy, e_en}));
  endtask

  task automatic applyStimulus(input bit b0, input logic [3:0] r, input logic [3:0] fl);
    if (b0) begin
      bus0.req   = r;
      bus0.flush = fl;
    end else begin
      bus.req   = r;
      bus.flush = fl;
    end
  endtask

  task automatic setPayload(input bit b0, input int idx, input logic [2:0] n,
                            input logic [2:0] o, input logic [2:0] l);
    if (b0) begin
      bus0.req_note[idx*NOTE_BITS +: NOTE_BITS] = n;
      bus0.req_oct[idx*OCT_BITS +: OCT_BITS]    = o;
      bus0.req_len[idx*LEN_BITS +: LEN_BITS]    = l;
    end else begin
      bus.req_note[idx*NOTE_BITS +: NOTE_BITS] = n;
      bus.req_oct[idx*OCT_BITS +: OCT_BITS]    = o;
      bus.req_len[idx*LEN_BITS +: LEN_BITS]    = l;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_note = '0;  bus.req_oct = '0;  bus.req_len = '0;
    bus0.req_note = '0; bus0.req_oct = '0; bus0.req_len = '0;
    applyStimulus(0, 4'b0000, 4'b0000);
    applyStimulus(1, 4'b0000, 4'b0000);

    rst = 1'b1;
    step(2);
    checkOutput(0, "reset", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    checkVal("reset_note", 32'(bus.snd_note), 32'd0);
    checkVal("reset_oct", 32'(bus.snd_oct), 32'd0);
    checkOutput(1, "reset_g0", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    checkOutput(0, "idle_noreq", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Single note: ack at cycle 1, snd_en cycles 1..16, done at 17, idle at 21.
    setPayload(0, 2, 3'd3, 3'd4, 3'd1);
    applyStimulus(0, 4'b0100, 4'b0000);
    step(1);
    checkOutput(0, "single_ack", 4'b0100, 4'b0, 4'b0100, 1'b1, 1'b1);
    checkVal("single_note", 32'(bus.snd_note), 32'd3);
    checkVal("single_oct", 32'(bus.snd_oct), 32'd4);
    applyStimulus(0, 4'b0000, 4'b0000);
    setPayload(0, 2, 3'd7, 3'd7, 3'd7);
    en_cnt = 1;
    for (int k = 2; k <= 16; k++) begin
      step(1);
      if (bus.snd_en === 1'b1) en_cnt++;
    end
    checkVal("single_en_cycles", 32'(en_cnt), 32'd16);
    step(1);
    checkOutput(0, "single_done", 4'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
    checkVal("single_note_hold", 32'(bus.snd_note), 32'd3);
    step(3);
    checkOutput(0, "single_gap_end", 4'b0, 4'b0, 4'b0100, 1'b1, 1'b0);
    step(1);
    checkOutput(0, "single_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Simultaneous requests: index 1 first, index 3 waits through note and gap.
    setPayload(0, 1, 3'd5, 3'd2, 3'd0);
    setPayload(0, 3, 3'd7, 3'd6, 3'd0);
    applyStimulus(0, 4'b1010, 4'b0000);
    step(1);
    checkOutput(0, "prio_ack1", 4'b0010, 4'b0, 4'b0010, 1'b1, 1'b1);
    checkVal("prio_note1", 32'(bus.snd_note), 32'd5);
    applyStimulus(0, 4'b1000, 4'b0000);
    step(7);
    checkOutput(0, "prio_play1_last", 4'b0, 4'b0, 4'b0010, 1'b1, 1'b1);
    step(1);
    checkOutput(0, "prio_done1", 4'b0, 4'b0010, 4'b0010, 1'b1, 1'b0);
    step(4);
    checkOutput(0, "prio_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    step(1);
    checkOutput(0, "prio_ack3", 4'b1000, 4'b0, 4'b1000, 1'b1, 1'b1);
    checkVal("prio_note3", 32'({bus.snd_note, bus.snd_oct}), 32'({3'd7, 3'd6}));
    applyStimulus(0, 4'b0000, 4'b0000);
    step(8);
    checkOutput(0, "prio_done3", 4'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    step(4);
    checkOutput(0, "prio_idle3", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Request and flush from the same requester while idle: not granted.
    setPayload(0, 2, 3'd1, 3'd1, 3'd0);
    applyStimulus(0, 4'b0100, 4'b0100);
    step(1);
    checkOutput(0, "idle_req_flush", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(0, 4'b0000, 4'b0000);

    // Rest note: slot occupied silently for 8 cycles.
    setPayload(0, 0, 3'd0, 3'd3, 3'd0);
    applyStimulus(0, 4'b0001, 4'b0000);
    step(1);
    checkOutput(0, "rest_ack", 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(0, 4'b0000, 4'b0000);
    oh_ok = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (bus.grant !== 4'b0001 || bus.snd_en !== 1'b0) oh_ok = 1'b0;
    end
    checkVal("rest_grant_onehot", 32'(oh_ok), 32'd1);
    step(1);
    checkOutput(0, "rest_done", 4'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4);
    checkOutput(0, "rest_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Flush by the owner five cycles in; pending req[0] acked right after.
    setPayload(0, 1, 3'd2, 3'd1, 3'd3);
    applyStimulus(0, 4'b0010, 4'b0000);
    step(1);
    checkOutput(0, "flush_ack", 4'b0010, 4'b0, 4'b0010, 1'b1, 1'b1);
    applyStimulus(0, 4'b0000, 4'b0000);
    step(5);
    setPayload(0, 0, 3'd6, 3'd5, 3'd0);
    applyStimulus(0, 4'b0001, 4'b0010);
    step(1);
    checkOutput(0, "flush_stop", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(0, 4'b0001, 4'b0000);
    step(1);
    checkOutput(0, "flush_next_ack", 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b1);
    checkVal("flush_next_note", 32'(bus.snd_note), 32'd6);
    applyStimulus(0, 4'b0000, 4'b0000);
    step(2);
    applyStimulus(0, 4'b0000, 4'b0100);
    step(1);
    applyStimulus(0, 4'b0000, 4'b0000);
    step(4);
    checkOutput(0, "nonowner_flush_play", 4'b0, 4'b0, 4'b0001, 1'b1, 1'b1);
    step(1);
    checkOutput(0, "nonowner_flush_done", 4'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4);
    checkOutput(0, "flush_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Reset mid-note; req[3] held through reset is acked one cycle after release.
    setPayload(0, 2, 3'd4, 3'd5, 3'd2);
    applyStimulus(0, 4'b0100, 4'b0000);
    step(1);
    checkOutput(0, "rstmid_ack", 4'b0100, 4'b0, 4'b0100, 1'b1, 1'b1);
    applyStimulus(0, 4'b0000, 4'b0000);
    step(3);
    rst = 1'b1;
    setPayload(0, 3, 3'd1, 3'd2, 3'd0);
    applyStimulus(0, 4'b1000, 4'b0000);
    step(1);
    checkOutput(0, "rst_mid", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    checkVal("rst_mid_payload", 32'({bus.snd_note, bus.snd_oct}), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    checkOutput(0, "rst_release_ack", 4'b1000, 4'b0, 4'b1000, 1'b1, 1'b1);
    checkVal("rst_release_payload", 32'({bus.snd_note, bus.snd_oct}), 32'({3'd1, 3'd2}));
    applyStimulus(0, 4'b0000, 4'b0000);
    step(8);
    checkOutput(0, "rst_release_done", 4'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
    step(4);

    // Longest length code: exactly 64 cycles of PLAY.
    setPayload(0, 1, 3'd1, 3'd0, 3'd7);
    applyStimulus(0, 4'b0010, 4'b0000);
    step(1);
    checkOutput(0, "len7_ack", 4'b0010, 4'b0, 4'b0010, 1'b1, 1'b1);
    applyStimulus(0, 4'b0000, 4'b0000);
    en_cnt = 1;
    for (int k = 1; k <= 63; k++) begin
      step(1);
      if (bus.snd_en === 1'b1 && bus.done === 4'b0000) en_cnt++;
    end
    checkVal("len7_en_cycles", 32'(en_cnt), 32'd64);
    step(1);
    checkOutput(0, "len7_done", 4'b0, 4'b0010, 4'b0010, 1'b1, 1'b0);
    step(4);
    checkOutput(0, "len7_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // No-gap build: done and idle together, next ack on the following cycle.
    setPayload(1, 0, 3'd6, 3'd2, 3'd0);
    setPayload(1, 2, 3'd3, 3'd3, 3'd0);
    applyStimulus(1, 4'b0101, 4'b0000);
    step(1);
    checkOutput(1, "g0_ack0", 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(1, 4'b0100, 4'b0000);
    step(7);
    checkOutput(1, "g0_play_last", 4'b0, 4'b0, 4'b0001, 1'b1, 1'b1);
    step(1);
    checkOutput(1, "g0_done", 4'b0, 4'b0001, 4'b0, 1'b0, 1'b0);
    step(1);
    checkOutput(1, "g0_b2b_ack", 4'b0100, 4'b0, 4'b0100, 1'b1, 1'b1);
    checkVal("g0_b2b_note", 32'(bus0.snd_note), 32'd3);
    applyStimulus(1, 4'b0000, 4'b0000);
    step(8);
    checkOutput(1, "g0_done2", 4'b0, 4'b0100, 4'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
